// File: rtl/cordic_fixedpoint_accumphase.sv
// CORDIC phase accumulator: sums +/- arctan(2^-i) per externally supplied rotation
// direction, then applies a quadrant pre-rotation offset to form a 22-bit phase (2^21 = pi).
module cordic_fixedpoint_accumphase #(
  parameter int NITER = 16
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iStart,
  input  logic [1:0]  iQuadrant,
  input  logic        iDir_valid,
  input  logic        iDir,
  output logic [3:0]  oPhase_addr,
  output logic        oBusy,
  output logic        oValid,
  output logic [21:0] oPhase,
  output logic [20:0] oPhase_abs,
  output logic        oPhase_sign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NITER - 1);

  // round(atan(2^-i) * 2^21 / pi)
  function automatic logic [20:0] theta_rom(input logic [3:0] idx);
    logic [20:0] t;
    case (idx)
      4'd0:    t = 21'd524288;
      4'd1:    t = 21'd309505;
      4'd2:    t = 21'd163534;
      4'd3:    t = 21'd83012;
      4'd4:    t = 21'd41667;
      4'd5:    t = 21'd20854;
      4'd6:    t = 21'd10430;
      4'd7:    t = 21'd5215;
      4'd8:    t = 21'd2608;
      4'd9:    t = 21'd1304;
      4'd10:   t = 21'd652;
      4'd11:   t = 21'd326;
      4'd12:   t = 21'd163;
      4'd13:   t = 21'd81;
      4'd14:   t = 21'd41;
      4'd15:   t = 21'd20;
      default: t = 21'd0;
    endcase
    return t;
  endfunction

  // -pi has no positive 21-bit counterpart, so it clips to the largest magnitude
  function automatic logic [20:0] phase_magnitude(input logic [21:0] p);
    logic [21:0] neg;
    logic [20:0] m;
    neg = 22'd0 - p;
    if (!p[21]) begin
      m = p[20:0];
    end else if (p == 22'h200000) begin
      m = 21'h1FFFFF;
    end else begin
      m = neg[20:0];
    end
    return m;
  endfunction

  state_t      state_r, state_s;
  logic [21:0] acc_r;
  logic [3:0]  cnt_r;
  logic [1:0]  quad_r;
  logic [21:0] phase_r;
  logic [20:0] abs_r;
  logic        sign_r;
  logic        valid_r;
  logic        busy_r;

  logic        accept_s, step_s, last_s;
  logic [20:0] theta_s;
  logic [21:0] delta_s, offset_s, fix_phase_s;

  // Handshake qualifiers
  always_comb begin
    accept_s = (state_r == IDLE) && iStart;
    step_s   = (state_r == RUN) && iDir_valid;
    last_s   = step_s && (cnt_r == LAST_IDX);
  end

  // Micro-rotation angle, quadrant offset and final phase
  always_comb begin
    theta_s = theta_rom(cnt_r);
    if (iDir) begin
      delta_s = 22'd0 - {1'b0, theta_s};
    end else begin
      delta_s = {1'b0, theta_s};
    end
    case (quad_r)
      2'b00:   offset_s = 22'h000000;
      2'b01:   offset_s = 22'h100000;
      2'b10:   offset_s = 22'h300000;
      2'b11:   offset_s = 22'h200000;
      default: offset_s = 22'h000000;
    endcase
    fix_phase_s = acc_r + offset_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (iStart) state_s = RUN;
        else        state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = FIX;
        else        state_s = RUN;
      end
      FIX:     state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge iClk) begin
    if (!iReset_n) state_r <= IDLE;
    else           state_r <= state_s;
  end

  // Accumulator, iteration counter and quadrant latch; cnt returns to 0 on leaving RUN
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      acc_r  <= 22'd0;
      cnt_r  <= 4'd0;
      quad_r <= 2'd0;
    end else if (accept_s) begin
      acc_r  <= 22'd0;
      cnt_r  <= 4'd0;
      quad_r <= iQuadrant;
    end else if (step_s) begin
      acc_r  <= acc_r + delta_s;
      cnt_r  <= last_s ? 4'd0 : cnt_r + 4'd1;
    end else begin
      acc_r  <= acc_r;
      cnt_r  <= cnt_r;
    end
  end

  // Result and status registers
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      phase_r <= 22'd0;
      abs_r   <= 21'd0;
      sign_r  <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      if (state_r == FIX) begin
        phase_r <= fix_phase_s;
        abs_r   <= phase_magnitude(fix_phase_s);
        sign_r  <= fix_phase_s[21];
      end
      valid_r <= (state_r == FIX);
      busy_r  <= (state_s == RUN) || (state_s == FIX);
    end
  end

  assign oPhase_addr = cnt_r;
  assign oBusy       = busy_r;
  assign oValid      = valid_r;
  assign oPhase      = phase_r;
  assign oPhase_abs  = abs_r;
  assign oPhase_sign = sign_r;

endmodule

// File: tb/tb_cordic_fixedpoint_accumphase.sv
// Scoreboard bench for cordic_fixedpoint_accumphase: expected phases come from an
// arctan table computed in real arithmetic and a wrap-around accumulator model.
module tb_cordic_fixedpoint_accumphase;

  localparam int NITER = 16;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iStart = 1'b0;
  logic [1:0]  iQuadrant = 2'd0;
  logic        iDir_valid = 1'b0;
  logic        iDir = 1'b0;
  logic [3:0]  oPhase_addr;
  logic        oBusy, oValid, oPhase_sign;
  logic [21:0] oPhase;
  logic [20:0] oPhase_abs;

  cordic_fixedpoint_accumphase #(.NITER(NITER)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iStart(iStart), .iQuadrant(iQuadrant),
    .iDir_valid(iDir_valid), .iDir(iDir), .oPhase_addr(oPhase_addr), .oBusy(oBusy),
    .oValid(oValid), .oPhase(oPhase), .oPhase_abs(oPhase_abs), .oPhase_sign(oPhase_sign)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [21:0] phase;
    logic [20:0] mag;
    logic        sign;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   bt[NITER];
  int   total = 0;
  int   bad = 0;

  logic        o_seen, o_addr_ok, o_busy_ok, o_one;
  int          o_lat;
  logic [21:0] o_ph;
  logic [20:0] o_abs;
  logic        o_sign;

  function automatic logic [21:0] model_phase(input logic [1:0] q, input logic [15:0] d);
    logic [21:0] a;
    a = 22'd0;
    for (int i = 0; i < NITER; i++) begin
      if (d[i]) a = a - 22'(bt[i]);
      else      a = a + 22'(bt[i]);
    end
    case (q)
      2'd1:    a = a + 22'(1 << 20);
      2'd2:    a = a - 22'(1 << 20);
      2'd3:    a = a + 22'(1 << 21);
      default: a = a;
    endcase
    return a;
  endfunction

  function automatic logic [20:0] model_abs(input logic [21:0] p);
    int s;
    s = int'($signed(p));
    if (s == -2097152) s = 2097151;
    else if (s < 0)    s = -s;
    return 21'(s);
  endfunction

  task automatic push_exp(input logic [1:0] q, input logic [15:0] d, input int stall_len);
    exp_t e;
    e.phase = model_phase(q, d);
    e.mag   = model_abs(e.phase);
    e.sign  = e.phase[21];
    e.lat   = NITER + 1 + stall_len;
    exp_q.push_back(e);
  endtask

  // Drives one conversion and records what the DUT produced; comparisons are done by the callers.
  task automatic run_op(input logic [1:0] quad, input logic [15:0] dirs,
                        input int stall_at, input int stall_len, input bit poke);
    int edges;
    o_seen = 1'b0; o_lat = -1; o_addr_ok = 1'b1; o_busy_ok = 1'b1; o_one = 1'b0;
    @(negedge iClk);
    iStart = 1'b1; iQuadrant = quad; iDir_valid = 1'b0;
    @(negedge iClk);
    iStart = 1'b0; edges = 0;
    for (int i = 0; i < NITER; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          if (oPhase_addr !== 4'(i)) o_addr_ok = 1'b0;
          iDir_valid = 1'b0; iDir = ~dirs[i];
          @(negedge iClk); edges++;
        end
      end
      if (oPhase_addr !== 4'(i)) o_addr_ok = 1'b0;
      if (oBusy !== 1'b1) o_busy_ok = 1'b0;
      iDir_valid = 1'b1; iDir = dirs[i];
      iStart = poke && (i == 3);
      if (poke) iQuadrant = ~quad;
      @(negedge iClk); edges++;
    end
    iStart = 1'b0; iQuadrant = quad;
    iDir_valid = 1'b1; iDir = 1'b1;
    for (int w = 0; w < 40 && !o_seen; w++) begin
      if (oValid === 1'b1) begin
        o_seen = 1'b1; o_lat = edges;
        o_ph = oPhase; o_abs = oPhase_abs; o_sign = oPhase_sign;
        if (oBusy !== 1'b0) o_busy_ok = 1'b0;
      end else begin
        if (oPhase_addr !== 4'd0) o_addr_ok = 1'b0;
        @(negedge iClk); edges++;
      end
    end
    if (o_seen) begin
      @(negedge iClk);
      o_one = (oValid === 1'b0);
    end
    iDir_valid = 1'b0; iDir = 1'b0;
  endtask

  task automatic test_reset();
    iReset_n = 1'b0; iStart = 1'b1; iQuadrant = 2'd3;
    repeat (2) @(negedge iClk);
    total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL reset_start_prio busy got=%b exp=0", oBusy); end
    iReset_n = 1'b1; iStart = 1'b0;
    @(negedge iClk);
    total++; if (oValid !== 1'b0) begin bad++; $display("FAIL reset valid got=%b exp=0", oValid); end
    total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", oBusy); end
    total++; if (oPhase !== 22'd0) begin bad++; $display("FAIL reset phase got=%h exp=0", oPhase); end
    total++; if (oPhase_abs !== 21'd0) begin bad++; $display("FAIL reset abs got=%h exp=0", oPhase_abs); end
    total++; if (oPhase_sign !== 1'b0) begin bad++; $display("FAIL reset sign got=%b exp=0", oPhase_sign); end
    total++; if (oPhase_addr !== 4'd0) begin bad++; $display("FAIL reset addr got=%h exp=0", oPhase_addr); end
  endtask

  task automatic test_quad0_pos();
    exp_t e;
    int sum;
    sum = 0;
    for (int i = 0; i < NITER; i++) sum += bt[i];
    push_exp(2'd0, 16'h0000, 0);
    run_op(2'd0, 16'h0000, -1, 0, 1'b0);
    e = exp_q.pop_front();
    total++; if (!o_seen) begin bad++; $display("FAIL q0 valid got=none exp=strobe"); end
    total++; if (o_lat !== e.lat) begin bad++; $display("FAIL q0 latency got=%0d exp=%0d", o_lat, e.lat); end
    total++; if (o_ph !== 22'(sum)) begin bad++; $display("FAIL q0 phase got=%h exp=%h", o_ph, 22'(sum)); end
    total++; if (o_abs !== e.mag) begin bad++; $display("FAIL q0 abs got=%h exp=%h", o_abs, e.mag); end
    total++; if (o_sign !== 1'b0) begin bad++; $display("FAIL q0 sign got=%b exp=0", o_sign); end
    total++; if (!o_addr_ok) begin bad++; $display("FAIL q0 addr got=wrong exp=cnt"); end
    total++; if (!o_busy_ok) begin bad++; $display("FAIL q0 busy got=wrong exp=run_fix"); end
    total++; if (!o_one) begin bad++; $display("FAIL q0 valid_width got=multi exp=1"); end
  endtask

  task automatic test_quad3_neg();
    exp_t e;
    int sum;
    sum = 0;
    for (int i = 0; i < NITER; i++) sum += bt[i];
    push_exp(2'd3, 16'hFFFF, 0);
    run_op(2'd3, 16'hFFFF, -1, 0, 1'b0);
    e = exp_q.pop_front();
    total++; if (!o_seen) begin bad++; $display("FAIL q3 valid got=none exp=strobe"); end
    total++; if (o_lat !== e.lat) begin bad++; $display("FAIL q3 latency got=%0d exp=%0d", o_lat, e.lat); end
    total++; if (o_ph !== 22'(2097152 - sum)) begin bad++; $display("FAIL q3 phase got=%h exp=%h", o_ph, 22'(2097152 - sum)); end
    total++; if (o_abs !== e.mag) begin bad++; $display("FAIL q3 abs got=%h exp=%h", o_abs, e.mag); end
    total++; if (o_sign !== e.sign) begin bad++; $display("FAIL q3 sign got=%b exp=%b", o_sign, e.sign); end
    total++; if (!o_one) begin bad++; $display("FAIL q3 valid_width got=multi exp=1"); end
  endtask

  task automatic test_stall();
    exp_t e;
    logic [21:0] ref_ph;
    push_exp(2'd1, 16'h5A3C, 0);
    run_op(2'd1, 16'h5A3C, -1, 0, 1'b0);
    e = exp_q.pop_front();
    ref_ph = o_ph;
    total++; if (o_ph !== e.phase) begin bad++; $display("FAIL nostall phase got=%h exp=%h", o_ph, e.phase); end
    push_exp(2'd1, 16'h5A3C, 5);
    run_op(2'd1, 16'h5A3C, 8, 5, 1'b0);
    e = exp_q.pop_front();
    total++; if (!o_seen) begin bad++; $display("FAIL stall valid got=none exp=strobe"); end
    total++; if (o_lat !== 22) begin bad++; $display("FAIL stall latency got=%0d exp=22", o_lat); end
    total++; if (o_ph !== ref_ph) begin bad++; $display("FAIL stall same_as_unstalled got=%h exp=%h", o_ph, ref_ph); end
    total++; if (o_abs !== e.mag) begin bad++; $display("FAIL stall abs got=%h exp=%h", o_abs, e.mag); end
    total++; if (!o_addr_ok) begin bad++; $display("FAIL stall addr_hold got=wrong exp=8"); end
    total++; if (!o_busy_ok) begin bad++; $display("FAIL stall busy got=wrong exp=run_fix"); end
  endtask

  task automatic test_start_in_run();
    exp_t e;
    push_exp(2'd2, 16'h1234, 0);
    run_op(2'd2, 16'h1234, -1, 0, 1'b1);
    e = exp_q.pop_front();
    total++; if (!o_seen) begin bad++; $display("FAIL poke valid got=none exp=strobe"); end
    total++; if (o_lat !== e.lat) begin bad++; $display("FAIL poke latency got=%0d exp=%0d", o_lat, e.lat); end
    total++; if (o_ph !== e.phase) begin bad++; $display("FAIL poke phase got=%h exp=%h", o_ph, e.phase); end
    total++; if (o_abs !== e.mag) begin bad++; $display("FAIL poke abs got=%h exp=%h", o_abs, e.mag); end
    total++; if (o_sign !== e.sign) begin bad++; $display("FAIL poke sign got=%b exp=%b", o_sign, e.sign); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [1:0]  q;
    logic [15:0] d;
    int sa, sl;
    for (int n = 0; n < 8; n++) begin
      q  = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      sa = $urandom_range(0, 15);
      sl = $urandom_range(0, 3);
      push_exp(q, d, sl);
      run_op(q, d, sa, sl, 1'b0);
      e = exp_q.pop_front();
      total++; if (o_lat !== e.lat) begin bad++; $display("FAIL b2b[%0d] latency got=%0d exp=%0d", n, o_lat, e.lat); end
      total++; if (o_ph !== e.phase) begin bad++; $display("FAIL b2b[%0d] phase got=%h exp=%h", n, o_ph, e.phase); end
      total++; if (o_abs !== e.mag) begin bad++; $display("FAIL b2b[%0d] abs got=%h exp=%h", n, o_abs, e.mag); end
      total++; if (o_sign !== e.sign) begin bad++; $display("FAIL b2b[%0d] sign got=%b exp=%b", n, o_sign, e.sign); end
      total++; if (!o_addr_ok) begin bad++; $display("FAIL b2b[%0d] addr got=wrong exp=cnt", n); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int vcount;
    @(negedge iClk);
    iStart = 1'b1; iQuadrant = 2'd3;
    @(negedge iClk);
    iStart = 1'b0;
    for (int i = 0; i < 8; i++) begin
      iDir_valid = 1'b1; iDir = i[0];
      @(negedge iClk);
    end
    total++; if (oPhase_addr !== 4'd8) begin bad++; $display("FAIL rstmid pre_addr got=%h exp=8", oPhase_addr); end
    iReset_n = 1'b0;
    @(negedge iClk);
    iReset_n = 1'b1;
    total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL rstmid busy got=%b exp=0", oBusy); end
    total++; if (oPhase !== 22'd0) begin bad++; $display("FAIL rstmid phase got=%h exp=0", oPhase); end
    total++; if (oPhase_abs !== 21'd0) begin bad++; $display("FAIL rstmid abs got=%h exp=0", oPhase_abs); end
    total++; if (oPhase_sign !== 1'b0) begin bad++; $display("FAIL rstmid sign got=%b exp=0", oPhase_sign); end
    total++; if (oPhase_addr !== 4'd0) begin bad++; $display("FAIL rstmid addr got=%h exp=0", oPhase_addr); end
    vcount = 0;
    for (int w = 0; w < 25; w++) begin
      if (oValid === 1'b1) vcount++;
      @(negedge iClk);
    end
    iDir_valid = 1'b0;
    total++; if (vcount !== 0) begin bad++; $display("FAIL rstmid no_valid got=%0d exp=0", vcount); end
    push_exp(2'd1, 16'hC3A5, 0);
    run_op(2'd1, 16'hC3A5, -1, 0, 1'b0);
    e = exp_q.pop_front();
    total++; if (o_lat !== e.lat) begin bad++; $display("FAIL rstmid fresh_latency got=%0d exp=%0d", o_lat, e.lat); end
    total++; if (o_ph !== e.phase) begin bad++; $display("FAIL rstmid fresh_phase got=%h exp=%h", o_ph, e.phase); end
    total++; if (o_abs !== e.mag) begin bad++; $display("FAIL rstmid fresh_abs got=%h exp=%h", o_abs, e.mag); end
  endtask

  initial begin
    real x;
    x = 1.0;
    for (int i = 0; i < NITER; i++) begin
      bt[i] = $rtoi($floor($atan(x) * 2097152.0 / 3.14159265358979323846 + 0.5));
      x = x / 2.0;
    end
    test_reset();
    test_quad0_pos();
    test_quad3_neg();
    test_stall();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
